// File: rtl/multiplier_block_pkg.sv
// Shared defaults, FSM state encoding and a modular multiply helper for the inverse multiplier.
// Latency: n/a (package). Backpressure: n/a.
// Contents: DEF_WIDTH / DEF_CONST / DEF_BITS_PER_CYCLE, state_e {IDLE,RUN,DONE}, mod_mul(a,b).
package multiplier_block_pkg;

   localparam int unsigned DEF_WIDTH          = 32;
   localparam int unsigned DEF_CONST          = 24465;  // 0x5F91, must be odd
   localparam int unsigned DEF_BITS_PER_CYCLE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Product truncated to DEF_WIDTH bits, i.e. a*b mod 2^DEF_WIDTH.
   function automatic logic [DEF_WIDTH-1:0] mod_mul(input logic [DEF_WIDTH-1:0] a,
                                                    input logic [DEF_WIDTH-1:0] b);
      return a * b;
   endfunction

endpackage

// File: rtl/multiplier_block_inv_if.sv
// Valid/ready handshake bundle between the inverse multiplier and its neighbours.
// Latency: n/a (wiring only). Backpressure: carried by o_ready (input side) and i_ready (output side).
// Signals: i_valid/o_ready/i_data0 (product in), o_valid/i_ready/o_data0 (recovered word out), o_busy.
interface multiplier_block_inv_if
   import multiplier_block_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data0;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data0;
   logic             o_busy;

   modport slave (
      input  i_valid, i_data0, i_ready,
      output o_ready, o_valid, o_data0, o_busy
   );

   modport master (
      output i_valid, i_data0, i_ready,
      input  o_ready, o_valid, o_data0, o_busy
   );

endinterface

// File: rtl/multiplier_block_inv_step.sv
// One Hensel-lifting step: resolves bit k of x from residual bit k and removes CONST<<k from r.
// Latency: combinational. Backpressure: none.
// Ports: r_in/x_in (residual, partial x), k (bit index), r_out/x_out (updated residual, partial x).
module multiplier_block_inv_step
   import multiplier_block_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CONST = DEF_CONST,
   parameter int unsigned KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] x_out
);

   localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST);

   logic hit;

   // Bits below k are already zero, and CONST is odd, so subtracting CONST<<k
   // clears bit k without touching anything already resolved.
   assign hit   = r_in[k];
   assign r_out = hit ? (r_in - (CONST_W << k)) : r_in;
   assign x_out = hit ? (x_in | (WIDTH'(1) << k)) : x_in;

endmodule

// File: rtl/multiplier_block_inv.sv
// Recovers x from y = x*CONST mod 2^WIDTH, resolving BITS_PER_CYCLE bits of x per cycle LSB first.
// Latency: o_valid in the cycle after the N-th RUN edge following accept (N = WIDTH/BITS_PER_CYCLE).
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready.
// Ports: i_clk, i_rst (sync, active-high), bus (slave side of multiplier_block_inv_if).
module multiplier_block_inv
   import multiplier_block_pkg::*;
#(
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned CONST          = DEF_CONST,
   parameter int unsigned BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   multiplier_block_inv_if.slave bus
);

   localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // An even constant has no inverse mod 2^WIDTH; a non-dividing step size
   // would leave the top bits unresolved.
   if ((CONST % 2) == 0) begin : g_bad_const
      $error("multiplier_block_inv: CONST must be odd");
   end
   if ((BITS_PER_CYCLE == 0) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_bpc
      $error("multiplier_block_inv: BITS_PER_CYCLE must divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Step chain: stage j works on bit count*B + j.
   logic [WIDTH-1:0] r_chain [BITS_PER_CYCLE+1];
   logic [WIDTH-1:0] x_chain [BITS_PER_CYCLE+1];

   assign r_chain[0] = r_q;
   assign x_chain[0] = x_q;

   for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
      logic [KW-1:0] k;
      assign k = KW'(count_q * BITS_PER_CYCLE + j);

      multiplier_block_inv_step #(
         .WIDTH (WIDTH),
         .CONST (CONST),
         .KW    (KW)
      ) u_step (
         .r_in  (r_chain[j]),
         .x_in  (x_chain[j]),
         .k     (k),
         .r_out (r_chain[j+1]),
         .x_out (x_chain[j+1])
      );
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      x_d     = x_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               state_d = RUN;
               r_d     = bus.i_data0;
               x_d     = '0;
               count_d = '0;
            end
         end
         RUN: begin
            r_d     = r_chain[BITS_PER_CYCLE];
            x_d     = x_chain[BITS_PER_CYCLE];
            count_d = count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
               state_d = DONE;
               data_d  = x_chain[BITS_PER_CYCLE];
               valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.i_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         x_q     <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         x_q     <= x_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_ready = (state_q == IDLE);
   assign bus.o_busy  = (state_q != IDLE);
   assign bus.o_valid = valid_q;
   assign bus.o_data0 = data_q;

endmodule

// File: tb/tb_multiplier_block_inv.sv
// Scoreboard bench for multiplier_block_inv at BITS_PER_CYCLE 1, 4 and 32.
// Latency: checks result latency N per word and N+2 back-to-back spacing.
// Backpressure: exercises held results under i_ready low and reset mid-operation.
module tb_multiplier_block_inv;
   import multiplier_block_pkg::*;

   localparam int unsigned W  = DEF_WIDTH;
   localparam int unsigned C  = DEF_CONST;
   localparam int          NI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic         vld    [NI];
   logic [W-1:0] dat    [NI];
   logic [W-1:0] expx   [NI];
   logic         rdy    [NI];
   logic         o_rdy_w[NI];
   logic         o_vld_w[NI];
   logic [W-1:0] o_dat_w[NI];
   logic         o_bsy_w[NI];
   bit           done_rand[NI];

   int cyc   = 0;
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned B = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
      localparam int unsigned N = W / B;

      multiplier_block_inv_if #(.WIDTH(W)) bus ();

      assign bus.i_valid = vld[g];
      assign bus.i_data0 = dat[g];
      assign bus.i_ready = rdy[g];
      assign o_rdy_w[g]  = bus.o_ready;
      assign o_vld_w[g]  = bus.o_valid;
      assign o_dat_w[g]  = bus.o_data0;
      assign o_bsy_w[g]  = bus.o_busy;

      multiplier_block_inv #(
         .WIDTH          (W),
         .CONST          (C),
         .BITS_PER_CYCLE (B)
      ) u_dut (
         .i_clk (clk),
         .i_rst (rst),
         .bus   (bus)
      );

      logic [W-1:0] exp_q [$];
      int           acc_q [$];

      // Pushes the expected word on each input handshake, checks data and latency
      // on each output handshake. A reset discards everything in flight.
      initial begin
         int           first_v;
         bit           v_prev;
         logic [W-1:0] xe;
         int           a;
         first_v = 0;
         v_prev  = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               exp_q.delete();
               acc_q.delete();
               v_prev = 1'b0;
            end else begin
               if (vld[g] && bus.o_ready) begin
                  exp_q.push_back(expx[g]);
                  acc_q.push_back(cyc + 1);
               end
               if (bus.o_valid && !v_prev) first_v = cyc;
               if (bus.o_valid && rdy[g]) begin
                  check_eq($sformatf("b%0d_result_expected", B), W'(exp_q.size() > 0), W'(1));
                  if (exp_q.size() > 0) begin
                     xe = exp_q.pop_front();
                     a  = acc_q.pop_front();
                     check_eq($sformatf("b%0d_data y*inv", B), bus.o_data0, xe);
                     check_eq($sformatf("b%0d_latency", B), W'(first_v - a), W'(N));
                  end
               end
               v_prev = bus.o_valid;
            end
         end
      end
   end

   // Drive one word and hold i_valid until it is accepted; returns the accept edge number.
   task automatic send(input int g, input logic [W-1:0] y, input logic [W-1:0] x, output int acc);
      int budget;
      bit got;
      budget = 0;
      got    = 1'b0;
      acc    = -1;
      vld[g]  = 1'b1;
      dat[g]  = y;
      expx[g] = x;
      while (!got && budget < 300) begin
         @(negedge clk);
         if (o_rdy_w[g]) begin
            got = 1'b1;
            acc = cyc + 1;
         end
         @(posedge clk);
         #1;
         budget++;
      end
      vld[g] = 1'b0;
      check_eq($sformatf("accept_in_time_%0d", g), W'(got), W'(1));
   endtask

   task automatic drain();
      int budget;
      int total;
      budget = 0;
      total  = g_inst[0].exp_q.size() + g_inst[1].exp_q.size() + g_inst[2].exp_q.size();
      while (total != 0 && budget < 3000) begin
         @(negedge clk);
         budget++;
         total = g_inst[0].exp_q.size() + g_inst[1].exp_q.size() + g_inst[2].exp_q.size();
      end
      check_eq("drain_outstanding", W'(total), W'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic rand_drive(input int g, input int n);
      logic [W-1:0] x;
      int           a;
      for (int i = 0; i < n; i++) begin
         x = W'($urandom());
         send(g, mod_mul(x, W'(C)), x, a);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      done_rand[g] = 1'b1;
   endtask

   task automatic rand_bp(input int g);
      while (!done_rand[g]) begin
         @(posedge clk);
         #1;
         rdy[g] = ($urandom_range(0, 3) != 0);
      end
      rdy[g] = 1'b1;
   endtask

   logic [W-1:0] dir_y [4];
   logic [W-1:0] dir_x [4];

   initial begin
      int  acc;
      int  prev_acc;
      int  budget;
      bit  seen;

      for (int i = 0; i < NI; i++) begin
         vld[i]       = 1'b0;
         dat[i]       = '0;
         expx[i]      = '0;
         rdy[i]       = 1'b1;
         done_rand[i] = 1'b0;
      end
      dir_y[0] = 32'h00011EB3; dir_x[0] = 32'h00000003;
      dir_y[1] = 32'h5F910000; dir_x[1] = 32'h00010000;
      dir_y[2] = 32'hFFFFA06F; dir_x[2] = 32'hFFFFFFFF;
      dir_y[3] = 32'h00000000; dir_x[3] = 32'h00000000;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_o_valid", W'(o_vld_w[0]), W'(0));
      check_eq("rst_o_ready", W'(o_rdy_w[0]), W'(1));
      check_eq("rst_o_busy",  W'(o_bsy_w[0]), W'(0));
      check_eq("rst_o_data0", o_dat_w[0], W'(0));
      @(posedge clk);
      #1;

      // Directed words, back-to-back with i_ready high: spacing N+2
      prev_acc = -1;
      for (int i = 0; i < 4; i++) begin
         send(0, dir_y[i], dir_x[i], acc);
         if (i > 0) check_eq("b2b_spacing", W'(acc - prev_acc), W'(34));
         prev_acc = acc;
      end
      drain();

      // Backpressure: result held, second word held in i_valid until IDLE
      rdy[0] = 1'b0;
      send(0, 32'h5F910000, 32'h00010000, acc);
      vld[0]  = 1'b1;
      dat[0]  = 32'h00011EB3;
      expx[0] = 32'h00000003;
      budget  = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!o_vld_w[0] && budget < 100);
      check_eq("bp_valid_seen", W'(o_vld_w[0]), W'(1));
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_o_valid_held", W'(o_vld_w[0]), W'(1));
         check_eq("bp_o_data0_held", o_dat_w[0], W'(32'h00010000));
         check_eq("bp_o_ready_low",  W'(o_rdy_w[0]), W'(0));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rdy[0] = 1'b1;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!o_rdy_w[0] && budget < 100);
      check_eq("bp_second_accept", W'(o_rdy_w[0]), W'(1));
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      drain();

      // Reset at RUN step 10: word discarded, nothing emitted
      send(0, 32'hFFFFA06F, 32'hFFFFFFFF, acc);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_o_valid", W'(o_vld_w[0]), W'(0));
      check_eq("midrst_o_ready", W'(o_rdy_w[0]), W'(1));
      check_eq("midrst_o_data0", o_dat_w[0], W'(0));
      check_eq("midrst_o_busy",  W'(o_bsy_w[0]), W'(0));
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (o_vld_w[0]) seen = 1'b1;
      end
      check_eq("midrst_no_result", W'(seen), W'(0));
      @(posedge clk);
      #1;
      send(0, 32'hFFFFA06F, 32'hFFFFFFFF, acc);
      drain();

      // Random words on all three step widths with random output backpressure
      fork
         rand_drive(0, 250);
         rand_drive(1, 800);
         rand_drive(2, 1500);
         rand_bp(0);
         rand_bp(1);
         rand_bp(2);
      join
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
